// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and common widths.
package uart_pkg;

    localparam int unsigned MAX_REQ     = 4;
    localparam int unsigned UART_BYTE_W = 8;
    localparam int unsigned OWNER_W     = $clog2(MAX_REQ);

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Scans the valid vector starting at last_owner+1 (with wrap-around) and
// returns a one-hot pick of the first requester found, or zero if none.
//   valid      : per-requester request vector
//   last_owner : index of the requester served most recently
//   pick_c     : one-hot selection (combinational)
module rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [OWNER_W-1:0] last_owner,
    output logic [NUM_REQ-1:0] pick_c
);

    int unsigned idx;
    logic        found;

    // Walk offsets 1..NUM_REQ from the last owner; the first valid one wins.
    always_comb begin
        pick_c = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = 32'(last_owner) + 32'd1 + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!found && (j == idx) && valid[j]) begin
                    pick_c[j] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-atomic round-robin arbiter for the UART TX FIFO write port.
// A granted requester owns the FIFO until it hands over a byte flagged last.
// Optional stall abort is built when UART_ARB_TIMEOUT_EN is defined.
//   clock, reset_n      : clock, async active-low reset
//   req_valid/data/last : per-requester byte stream (requester i at data[8i+7:8i])
//   req_ready           : accept indication to the owner (combinational)
//   tx_fifo_full        : FIFO back-pressure
//   tx_fifo_write_en    : registered one-cycle write strobe
//   tx_fifo_data_in     : registered byte for the strobe
//   grant               : one-hot owner, zero when idle
//   busy                : high while a message is in flight
//   timeout_err         : one-cycle pulse on a stall abort
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 2700000
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           tx_fifo_full,
    output logic                           tx_fifo_write_en,
    output logic [UART_BYTE_W-1:0]         tx_fifo_data_in,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    output logic                           timeout_err
);

    arb_state_t             state_q, state_d;
    logic [NUM_REQ-1:0]     grant_d;
    logic [OWNER_W-1:0]     last_owner_q, last_owner_d;
    logic                   wr_en_d;
    logic [UART_BYTE_W-1:0] data_d;
    logic                   busy_d;
    logic [NUM_REQ-1:0]     pick_c;

    logic                   g_valid;
    logic                   g_last;
    logic [UART_BYTE_W-1:0] g_data;
    logic [OWNER_W-1:0]     g_idx;
    logic                   ready_bit;
    logic                   hs;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_d;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .valid      (req_valid),
        .last_owner (last_owner_q),
        .pick_c     (pick_c)
    );

    // Mux the owner's stream using the one-hot grant.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        g_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                g_valid = req_valid[k];
                g_last  = req_last[k];
                g_data  = req_data[k*UART_BYTE_W +: UART_BYTE_W];
                g_idx   = OWNER_W'(k);
            end
        end
    end

    // Next-state and ready logic. Ready is masked during the write cycle.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant;
        last_owner_d = last_owner_q;
        wr_en_d      = 1'b0;
        data_d       = tx_fifo_data_in;
        req_ready    = '0;
        ready_bit    = 1'b0;
        hs           = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        terr_d       = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (|req_valid) begin
                    grant_d = pick_c;
                    state_d = ARB_XFER;
                end
            end
            ARB_XFER: begin
                ready_bit = !tx_fifo_full && !tx_fifo_write_en;
                req_ready = grant & {NUM_REQ{ready_bit}};
                hs        = g_valid && ready_bit;
                if (hs) begin
                    wr_en_d = 1'b1;
                    data_d  = g_data;
                    if (g_last) begin
                        last_owner_d = g_idx;
                        grant_d      = '0;
                        state_d      = ARB_IDLE;
                    end
                end
`ifdef UART_ARB_TIMEOUT_EN
                // Only consecutive cycles with the owner's valid low count.
                if (g_valid) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    cnt_d        = '0;
                    terr_d       = 1'b1;
                    last_owner_d = g_idx;
                    grant_d      = '0;
                    state_d      = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d == ARB_XFER);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ARB_IDLE;
            grant            <= '0;
            last_owner_q     <= OWNER_W'(NUM_REQ - 1);
            tx_fifo_write_en <= 1'b0;
            tx_fifo_data_in  <= '0;
            busy             <= 1'b0;
        end else begin
            state_q          <= state_d;
            grant            <= grant_d;
            last_owner_q     <= last_owner_d;
            tx_fifo_write_en <= wr_en_d;
            tx_fifo_data_in  <= data_d;
            busy             <= busy_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Stall counter and abort pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            timeout_err <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            timeout_err <= terr_d;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with two requesters.
module tb_uart_tx_arbiter;

    logic        clock;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        tx_fifo_full;
    logic        tx_fifo_write_en;
    logic [7:0]  tx_fifo_data_in;
    logic [1:0]  grant;
    logic        busy;
    logic        timeout_err;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    logic [8:0]  rq0[$];
    logic [8:0]  rq1[$];
    logic [7:0]  exp_q[$];
    int          strobe_cyc[$];
    int          acc_cyc[2];
    int          gcyc[2];
    int          terr_cnt = 0;
    int          terr_cyc = 0;
    logic [1:0]  hs = 2'b00;
    logic [1:0]  prev_g = 2'b00;

    uart_tx_arbiter #(
        .NUM_REQ        (2),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_last         (req_last),
        .req_ready        (req_ready),
        .tx_fifo_full     (tx_fifo_full),
        .tx_fifo_write_en (tx_fifo_write_en),
        .tx_fifo_data_in  (tx_fifo_data_in),
        .grant            (grant),
        .busy             (busy),
        .timeout_err      (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #2;
    endtask

    task automatic load(input int r, input logic [7:0] b, input logic lst, input logic expect_it);
        if (r == 0) rq0.push_back({lst, b});
        else        rq1.push_back({lst, b});
        if (expect_it) exp_q.push_back(b);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        rq0.delete();
        rq1.delete();
        exp_q.delete();
        strobe_cyc.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && rq0.size() == 0 && rq1.size() == 0 && grant == 2'b00)
               && n < budget) begin
            tick();
            n++;
        end
        check({name, "_drain_timeout"}, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_strobes(input int cnt, input int budget);
        int n;
        n = 0;
        while (strobe_cyc.size() < cnt && n < budget) begin
            tick();
            n++;
        end
        check("strobe_wait_timeout", 32'(n < budget), 32'd1);
    endtask

    // Requester driver: consume the previous handshake, present queue heads, sample handshake.
    initial begin
        forever begin
            @(negedge clock);
            if (hs[0] && rq0.size() > 0) void'(rq0.pop_front());
            if (hs[1] && rq1.size() > 0) void'(rq1.pop_front());
            req_valid[0]    = (rq0.size() > 0);
            req_data[7:0]   = (rq0.size() > 0) ? rq0[0][7:0] : 8'h00;
            req_last[0]     = (rq0.size() > 0) ? rq0[0][8] : 1'b0;
            req_valid[1]    = (rq1.size() > 0);
            req_data[15:8]  = (rq1.size() > 0) ? rq1[0][7:0] : 8'h00;
            req_last[1]     = (rq1.size() > 0) ? rq1[0][8] : 1'b0;
            #3;
            hs = req_valid & req_ready;
            if (hs[0]) acc_cyc[0] = cyc;
            if (hs[1]) acc_cyc[1] = cyc;
        end
    end

    // Monitor: compare every strobe against the scoreboard, track grants and timeouts.
    initial begin
        forever begin
            @(negedge clock);
            if (tx_fifo_write_en) begin
                strobe_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {24'h0, tx_fifo_data_in}, 32'hFFFF_FFFF);
                end else begin
                    check("strobe_data", {24'h0, tx_fifo_data_in}, {24'h0, exp_q.pop_front()});
                end
            end
            if (timeout_err) begin
                terr_cnt++;
                terr_cyc = cyc;
            end
            if (grant != prev_g) begin
                if (grant == 2'b01) gcyc[0] = cyc;
                if (grant == 2'b10) gcyc[1] = cyc;
            end
            prev_g = grant;
            if (grant == 2'b11) check("grant_onehot", 32'(grant), 32'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pass_msg [6];
        pass_msg = '{8'h50, 8'h61, 8'h73, 8'h73, 8'h0D, 8'h0A};
        reset_n      = 1'b0;
        tx_fifo_full = 1'b0;
        req_valid    = 2'b00;
        req_data     = 16'h0000;
        req_last     = 2'b00;
        tick();
        tick();

        // Reset state
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_en", 32'(tx_fifo_write_en), 32'd0);
        check("rst_data", 32'(tx_fifo_data_in), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        reset_n = 1'b1;
        tick();

        // "Pass\r\n" from requester 0, strobes spaced by 2 cycles
        strobe_cyc.delete();
        for (int i = 0; i < 6; i++) load(0, pass_msg[i], (i == 5), 1'b1);
        wait_drain("pass", 100);
        check("pass_count", 32'(strobe_cyc.size()), 32'd6);
        for (int i = 1; i < strobe_cyc.size(); i++)
            check("pass_spacing", 32'(strobe_cyc[i] - strobe_cyc[i-1]), 32'd2);
        tick();
        check("pass_grant_idle", 32'(grant), 32'd0);
        check("pass_busy_idle", 32'(busy), 32'd0);

        // Simultaneous requests after reset: 0 first, 1 granted 2 cycles after 0's last
        apply_reset();
        load(0, 8'h10, 1'b0, 1'b1);
        load(0, 8'h11, 1'b0, 1'b1);
        load(0, 8'h12, 1'b1, 1'b1);
        load(1, 8'h20, 1'b0, 1'b1);
        load(1, 8'h21, 1'b1, 1'b1);
        wait_drain("dual", 100);
        check("dual_order", 32'(gcyc[0] < gcyc[1]), 32'd1);
        check("dual_turnaround", 32'(gcyc[1] - acc_cyc[0]), 32'd2);

        // FIFO full for 10 cycles mid-message
        strobe_cyc.delete();
        for (int i = 0; i < 6; i++) load(0, 8'h30 + 8'(i), (i == 5), 1'b1);
        wait_strobes(2, 50);
        tx_fifo_full = 1'b1;
        #1;
        check("full_ready", 32'(req_ready), 32'd0);
        for (int k = 1; k < 10; k++) begin
            tick();
            check("full_ready", 32'(req_ready), 32'd0);
            check("full_no_strobe", 32'(tx_fifo_write_en), 32'd0);
        end
        tick();
        tx_fifo_full = 1'b0;
        wait_drain("full", 100);
        check("full_count", 32'(strobe_cyc.size()), 32'd6);

        // Back-to-back single-byte messages alternate A B A B ...
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            load(0, 8'h41, 1'b1, 1'b0);
            load(1, 8'h42, 1'b1, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h41);
            exp_q.push_back(8'h42);
        end
        wait_drain("alt", 200);

        // Reset asserted after 2 of 6 bytes
        apply_reset();
        load(0, 8'h40, 1'b0, 1'b1);
        load(0, 8'h41, 1'b0, 1'b1);
        for (int i = 2; i < 6; i++) load(0, 8'h40 + 8'(i), (i == 5), 1'b0);
        wait_strobes(2, 50);
        check("mid_strobe_before_rst", 32'(tx_fifo_write_en), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_wr_en", 32'(tx_fifo_write_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        rq0.delete();
        rq1.delete();
        check("mid_rst_leftover", 32'(exp_q.size()), 32'd0);
        tick();
        tick();
        load(0, 8'h50, 1'b1, 1'b1);
        load(1, 8'h60, 1'b1, 1'b1);
        reset_n = 1'b1;
        wait_drain("post_rst", 100);
        check("post_rst_order", 32'(gcyc[0] < gcyc[1]), 32'd1);

`ifdef UART_ARB_TIMEOUT_EN
        // Owner stalls after 3 bytes; abort after 100 stall cycles
        apply_reset();
        terr_cnt = 0;
        load(0, 8'h70, 1'b0, 1'b1);
        load(0, 8'h71, 1'b0, 1'b1);
        load(0, 8'h72, 1'b0, 1'b1);
        load(1, 8'h80, 1'b1, 1'b1);
        wait_drain("timeout", 500);
        check("timeout_pulses", 32'(terr_cnt), 32'd1);
        check("timeout_at_stall_100", 32'(terr_cyc - acc_cyc[0]), 32'd101);
        check("timeout_next_grant", 32'(gcyc[1] - terr_cyc), 32'd1);
`else
        check("timeout_tied_low", 32'(terr_cnt), 32'd0);
`endif

        tick();
        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit FIFO write port between several byte-stream requesters, such as the SPI-to-UART echo path, the command parser's Pass/Fail responder and the debug string generator. Arbitration is round-robin and message-atomic. Once a requester is granted, it keeps the FIFO until it presents a byte flagged `last`, so messages never interleave on the wire. The block sits between the requester state machines in the top level and the `uart` instance's `tx_fifo_write_en` / `tx_fifo_data_in` inputs.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal range 2..4.
- `TIMEOUT_CYCLES`, default 2700000: stall limit in clocks (100 ms at 27 MHz); used only when `UART_ARB_TIMEOUT_EN` is defined.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clock`  in  1  system clock, 27 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester byte valid.
- `req_data`  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- `req_last`  in  NUM_REQ  byte is the final byte of the message.
- `req_ready`  out  NUM_REQ  byte accepted this cycle when both valid and ready are high.
- `tx_fifo_full`  in  1  UART TX FIFO full.
- `tx_fifo_write_en`  out  1  registered single-cycle write strobe.
- `tx_fifo_data_in`  out  8  registered byte, valid while the strobe is high.
- `grant`  out  NUM_REQ  one-hot owner of the FIFO; all zero when idle.
- `busy`  out  1  high in the XFER state.
- `timeout_err`  out  1  one-cycle pulse on a stall abort; tied to 0 without the macro.

## Operation
- FSM states: IDLE and XFER.
- IDLE:
  - `grant` is 0.
  - If any `req_valid` is high, select the first requester with valid high, scanning from `last_owner`+1 with wrap-around.
  - Register the selection into `grant` and go to XFER.
- XFER:
  - `req_ready[g]` = `!tx_fifo_full && !tx_fifo_write_en`. Every other `req_ready` bit is 0.
  - Handshake (valid and ready both high): register `req_data[g]` into `tx_fifo_data_in` and pulse `tx_fifo_write_en` on the next cycle.
  - If the accepted byte has `req_last` high: set `last_owner` to g, clear `grant` and go to IDLE.
  - `req_valid[g]` low with no `last` received: stay in XFER and hold the grant; the timeout rule applies when the macro is defined.
- Requesters must hold valid, data and last stable until ready.
- Requesters must not drop valid mid-byte.
- Single-byte messages are legal: valid and last high together.
- Non-granted requesters see ready at 0 and are served in rotation, so no requester starves.
- Reset values:
  - FSM is IDLE.
  - `grant`, `busy`, `tx_fifo_write_en`, `timeout_err` and `req_ready` are 0.
  - `tx_fifo_data_in` is 8'h00.
  - `last_owner` is NUM_REQ-1, so requester 0 wins first.
- Reset asserted mid-message:
  - Everything returns to reset values immediately.
  - The partial message is abandoned; no write strobe is emitted after reset asserts.

## Timing
- Request to grant: 1 cycle. `req_valid` sampled high in IDLE gives `grant` high on the next edge.
- Accept to FIFO write: 1 cycle, registered.
- Throughput: at most 1 byte per 2 clocks, because ready is masked during the write cycle. This is far above UART line rate.
- Message turnaround: after a `last` accept, the block spends 1 cycle in IDLE before the next grant. The minimum gap between messages is therefore 2 cycles.
- `tx_fifo_full`:
  - It is sampled combinationally into ready.
  - When full rises during the strobe cycle, no further byte is accepted until full falls.
- Simultaneous requests in IDLE: resolved by the rotation order only; the outcome is deterministic.

## Configuration
- Macro: `UART_ARB_TIMEOUT_EN`.
- Defined:
  - A counter (width $clog2(TIMEOUT_CYCLES+1)) counts consecutive XFER cycles with `req_valid[g]` low.
  - The counter clears on every handshake and on entry to XFER.
  - When the count reaches TIMEOUT_CYCLES: pulse `timeout_err` for 1 cycle, set `last_owner` to g, clear `grant`, go to IDLE.
  - No partial-message marker is written.
- Not defined:
  - No counter is built and `timeout_err` is constant 0.
  - A stalled owner holds the FIFO indefinitely.

## Structure
- Shared package `uart_pkg` holds:
  - the state typedef `arb_state_t` (ARB_IDLE, ARB_XFER);
  - `MAX_REQ` = 4;
  - `UART_BYTE_W` = 8.
- One sub-module, `rr_pick`: combinational round-robin selector.
  - Inputs: valid vector and `last_owner`.
  - Output: one-hot grant.
  - Instantiated once.

## Test plan
- Reset, then requester 0 sends "Pass\r\n" (50 61 73 73 0D 0A, last on 0A). Required: six strobes in order, spaced exactly 2 cycles apart, then `grant` back to 0.
- Requesters 0 and 1 both valid in the same cycle after reset. Required:
  - requester 0 is granted first;
  - its full message completes;
  - requester 1 is granted 2 cycles after requester 0's last accept;
  - no bytes interleave.
- `tx_fifo_full` forced high for 10 cycles mid-message. Required: no strobe and `req_ready` low throughout; the message resumes with the next byte intact and without duplication.
- Back-to-back single-byte messages, A from requester 0 and B from requester 1, repeated 4 times with both always valid. Required: output sequence A B A B A B A B.
- `reset_n` pulsed low after 2 of 6 bytes. Required: `grant`, strobe and busy go to 0 asynchronously; after release, requester 0 is served first.
- With `UART_ARB_TIMEOUT_EN` defined and TIMEOUT_CYCLES=100: the owner stalls after 3 bytes. Required: `timeout_err` pulses at stall cycle 100, then the next valid requester is granted 1 cycle later.
